mole_game_sequencer: RTL and testbench

//  Frame-synchronous game controller for Whack-A-Mole. It decides which mole the VGA pixel

---
 rtl/mole_game_sequencer.sv | 175 +++++++++++++++++
 tb/tb_mole_game_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mole_game_sequencer.sv
// Whack-A-Mole game controller: picks and times the visible mole, scores hits,
// counts misses and runs the game clock. Display outputs only move on frame_tick.
module mole_game_sequencer #(
    parameter int unsigned NUM_MOLES   = 9,
    parameter int unsigned UP_FRAMES   = 60,
    parameter int unsigned GAP_FRAMES  = 30,
    parameter int unsigned HIT_FRAMES  = 15,
    parameter int unsigned GAME_FRAMES = 1800,
    parameter int unsigned SCORE_W     = 8,
    parameter int unsigned TIMER_W     = 12,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 frame_tick,
    input  logic                 start,
    input  logic [NUM_MOLES-1:0] hit_btn,
    output logic [NUM_MOLES-1:0] mole_up,
    output logic                 hit_flash,
    output logic [SCORE_W-1:0]   score,
    output logic [SCORE_W-1:0]   miss_count,
    output logic [TIMER_W-1:0]   time_left,
    output logic                 game_active,
    output logic                 game_over
);

    localparam int unsigned IDX_W  = (NUM_MOLES > 2) ? $clog2(NUM_MOLES) : 1;
    localparam int unsigned FMAX_A = (UP_FRAMES > GAP_FRAMES) ? UP_FRAMES : GAP_FRAMES;
    localparam int unsigned FMAX   = (FMAX_A > HIT_FRAMES) ? FMAX_A : HIT_FRAMES;
    localparam int unsigned FCNT_W = $clog2(FMAX + 1);

    typedef enum logic [2:0] {IDLE, GAP, UP, HIT, OVER} state_t;

    state_t               state_q;
    logic [FCNT_W-1:0]    fcnt_q;
    logic [15:0]          lfsr_q;
    logic [15:0]          lfsr_d;
    logic                 start_q;
    logic                 hit_pend_q;
    logic [IDX_W-1:0]     idx_q;
    logic [NUM_MOLES-1:0] mole_up_q;
    logic                 hit_flash_q;
    logic [SCORE_W-1:0]   score_q;
    logic [SCORE_W-1:0]   miss_q;
    logic [TIMER_W-1:0]   time_left_q;
    logic [TIMER_W-1:0]   time_left_d;

    logic                 start_rise;
    logic                 hit_now;
    logic [4:0]           cand;
    logic [IDX_W-1:0]     pick_idx;
    logic [NUM_MOLES-1:0] pick_mask;

    // Galois LFSR step (taps 16,14,13,11) and saturating game-timer decrement
    always_comb begin
        lfsr_d      = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);
        time_left_d = (time_left_q == '0) ? '0 : time_left_q - TIMER_W'(1);
        start_rise  = start & ~start_q;
        // mole_up_q is one-hot on idx during UP, so masking selects the live button
        hit_now     = (state_q == UP) && !hit_pend_q && |(hit_btn & mole_up_q);
    end

    // Next mole choice: fold the LFSR nibble into range, then step past a repeat.
    // The modulo matches a single subtract for NUM_MOLES >= 8 and stays in range below that.
    always_comb begin
        cand = 5'(lfsr_q[3:0]) % 5'(NUM_MOLES);
        if (cand == 5'(idx_q)) begin
            cand = (cand + 5'd1 == 5'(NUM_MOLES)) ? 5'd0 : cand + 5'd1;
        end
        pick_idx  = IDX_W'(cand);
        pick_mask = NUM_MOLES'(1) << pick_idx;
    end

    // Game FSM with registered display outputs and counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            fcnt_q      <= '0;
            lfsr_q      <= LFSR_SEED;
            start_q     <= 1'b0;
            hit_pend_q  <= 1'b0;
            idx_q       <= '0;
            mole_up_q   <= '0;
            hit_flash_q <= 1'b0;
            score_q     <= '0;
            miss_q      <= '0;
            time_left_q <= '0;
        end else begin
            lfsr_q  <= lfsr_d;
            start_q <= start;

            // Scoring is independent of the frame-driven transitions below
            if (hit_now) begin
                hit_pend_q <= 1'b1;
                if (score_q != '1) begin
                    score_q <= score_q + SCORE_W'(1);
                end
            end

            case (state_q)
                IDLE, OVER: begin
                    if (start_rise) begin
                        score_q     <= '0;
                        miss_q      <= '0;
                        time_left_q <= TIMER_W'(GAME_FRAMES);
                        fcnt_q      <= '0;
                        state_q     <= GAP;
                    end
                end
                GAP, UP, HIT: begin
                    if (frame_tick) begin
                        time_left_q <= time_left_d;
                        if (time_left_d == '0) begin
                            state_q     <= OVER;
                            mole_up_q   <= '0;
                            hit_flash_q <= 1'b0;
                            fcnt_q      <= '0;
                        end else begin
                            case (state_q)
                                GAP: begin
                                    if (fcnt_q == FCNT_W'(GAP_FRAMES - 1)) begin
                                        idx_q      <= pick_idx;
                                        mole_up_q  <= pick_mask;
                                        hit_pend_q <= 1'b0;
                                        fcnt_q     <= '0;
                                        state_q    <= UP;
                                    end else begin
                                        fcnt_q <= fcnt_q + FCNT_W'(1);
                                    end
                                end
                                UP: begin
                                    if (hit_pend_q || hit_now) begin
                                        mole_up_q   <= '0;
                                        hit_flash_q <= 1'b1;
                                        fcnt_q      <= '0;
                                        state_q     <= HIT;
                                    end else if (fcnt_q == FCNT_W'(UP_FRAMES - 1)) begin
                                        mole_up_q <= '0;
                                        if (miss_q != '1) begin
                                            miss_q <= miss_q + SCORE_W'(1);
                                        end
                                        fcnt_q    <= '0;
                                        state_q   <= GAP;
                                    end else begin
                                        fcnt_q <= fcnt_q + FCNT_W'(1);
                                    end
                                end
                                HIT: begin
                                    if (fcnt_q == FCNT_W'(HIT_FRAMES - 1)) begin
                                        hit_flash_q <= 1'b0;
                                        fcnt_q      <= '0;
                                        state_q     <= GAP;
                                    end else begin
                                        fcnt_q <= fcnt_q + FCNT_W'(1);
                                    end
                                end
                                default: state_q <= IDLE;
                            endcase
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mole_up     = mole_up_q;
    assign hit_flash   = hit_flash_q;
    assign score       = score_q;
    assign miss_count  = miss_q;
    assign time_left   = time_left_q;
    assign game_active = (state_q == GAP) || (state_q == UP) || (state_q == HIT);
    assign game_over   = (state_q == OVER);

endmodule

// File: tb/tb_mole_game_sequencer.sv
// Directed bench for mole_game_sequencer: UP=4 GAP=2 HIT=2 GAME=40 frames,
// frame_tick every 20 clocks. A second instance with a 2-bit score auto-hits
// every mole to exercise score saturation.
module tb_mole_game_sequencer;

    logic        clk;
    logic        rst;
    logic        frame_tick;
    logic        start;
    logic [8:0]  hit_btn;
    logic [8:0]  mole_up;
    logic        hit_flash;
    logic [7:0]  score;
    logic [7:0]  miss_count;
    logic [11:0] time_left;
    logic        game_active;
    logic        game_over;

    logic [8:0]  sat_mole_up;
    logic        sat_hit_flash;
    logic [1:0]  sat_score;
    logic [1:0]  sat_miss;
    logic [11:0] sat_time_left;
    logic        sat_active;
    logic        sat_over;

    int errors = 0;
    int checks = 0;

    logic [8:0] saved_mask;
    logic [8:0] last_mask;
    logic [8:0] prev_up;

    mole_game_sequencer #(
        .NUM_MOLES(9), .UP_FRAMES(4), .GAP_FRAMES(2), .HIT_FRAMES(2),
        .GAME_FRAMES(40), .SCORE_W(8), .TIMER_W(12), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start),
        .hit_btn(hit_btn), .mole_up(mole_up), .hit_flash(hit_flash),
        .score(score), .miss_count(miss_count), .time_left(time_left),
        .game_active(game_active), .game_over(game_over)
    );

    mole_game_sequencer #(
        .NUM_MOLES(9), .UP_FRAMES(4), .GAP_FRAMES(2), .HIT_FRAMES(2),
        .GAME_FRAMES(40), .SCORE_W(2), .TIMER_W(12), .LFSR_SEED(16'hACE1)
    ) u_sat (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start),
        .hit_btn(sat_mole_up), .mole_up(sat_mole_up), .hit_flash(sat_hit_flash),
        .score(sat_score), .miss_count(sat_miss), .time_left(sat_time_left),
        .game_active(sat_active), .game_over(sat_over)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        frame_tick = 1'b0;
        forever begin
            repeat (19) @(negedge clk);
            frame_tick = 1'b1;
            @(negedge clk);
            frame_tick = 1'b0;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next frame_tick edge, then sample just after it
    task automatic next_tick();
        int unsigned n;
        n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (!frame_tick && n < 40);
        chk("tick_seen", {31'b0, frame_tick}, 32'd1);
        #1;
    endtask

    initial begin
        rst     = 1'b0;
        start   = 1'b0;
        hit_btn = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mole_up", 32'(mole_up), 32'd0);
        chk("rst_hit_flash", 32'(hit_flash), 32'd0);
        chk("rst_score", 32'(score), 32'd0);
        chk("rst_miss", 32'(miss_count), 32'd0);
        chk("rst_time_left", 32'(time_left), 32'd0);
        chk("rst_active", 32'(game_active), 32'd0);
        chk("rst_over", 32'(game_over), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // 1. Start edge -> GAP with full timer, blank for 2 frames, then one mole
        start = 1'b1;
        @(posedge clk);
        #1;
        chk("start_active", 32'(game_active), 32'd1);
        chk("start_time", 32'(time_left), 32'd40);
        chk("start_mole_up", 32'(mole_up), 32'd0);
        @(negedge clk);
        start = 1'b0;
        next_tick();
        chk("gap1_mole_up", 32'(mole_up), 32'd0);
        chk("gap1_time", 32'(time_left), 32'd39);
        next_tick();
        chk("up1_onehot", 32'($countones(mole_up)), 32'd1);
        chk("up1_time", 32'(time_left), 32'd38);
        saved_mask = mole_up;

        // 2. Hit mid-frame -> score next clk, mole holds, then 2 frames of flash
        repeat (5) @(posedge clk);
        @(negedge clk);
        hit_btn = mole_up;
        @(posedge clk);
        #1;
        chk("hit_score", 32'(score), 32'd1);
        chk("hit_mole_hold", 32'(mole_up), 32'(saved_mask));
        @(negedge clk);
        hit_btn = '0;
        next_tick();
        chk("hit1_mole_up", 32'(mole_up), 32'd0);
        chk("hit1_flash", 32'(hit_flash), 32'd1);
        chk("hit1_time", 32'(time_left), 32'd37);
        next_tick();
        chk("hit2_flash", 32'(hit_flash), 32'd1);
        next_tick();
        chk("hit_end_flash", 32'(hit_flash), 32'd0);
        chk("hit_end_time", 32'(time_left), 32'd35);
        last_mask = saved_mask;

        // 3. Wrong-bit pulse, then timeout -> miss
        next_tick();
        next_tick();
        chk("up2_onehot", 32'($countones(mole_up)), 32'd1);
        chk("up2_norepeat", 32'(mole_up != last_mask), 32'd1);
        last_mask = mole_up;
        repeat (5) @(posedge clk);
        @(negedge clk);
        hit_btn = ~mole_up;
        @(posedge clk);
        #1;
        chk("wrong_score", 32'(score), 32'd1);
        @(negedge clk);
        hit_btn = '0;
        next_tick();
        next_tick();
        next_tick();
        chk("up2_still_up", 32'(mole_up), 32'(last_mask));
        chk("up2_time", 32'(time_left), 32'd30);
        next_tick();
        chk("miss_mole_up", 32'(mole_up), 32'd0);
        chk("miss_count", 32'(miss_count), 32'd1);
        chk("miss_score", 32'(score), 32'd1);
        chk("miss_flash", 32'(hit_flash), 32'd0);

        // 4. Hit coincident with the 4th UP tick -> HIT wins over timeout
        next_tick();
        next_tick();
        chk("up3_onehot", 32'($countones(mole_up)), 32'd1);
        chk("up3_norepeat", 32'(mole_up != last_mask), 32'd1);
        last_mask = mole_up;
        next_tick();
        next_tick();
        next_tick();
        chk("up3_time", 32'(time_left), 32'd24);
        repeat (19) @(posedge clk);
        @(negedge clk);
        hit_btn = mole_up;
        @(posedge clk);
        #1;
        chk("coinc_score", 32'(score), 32'd2);
        chk("coinc_flash", 32'(hit_flash), 32'd1);
        chk("coinc_mole_up", 32'(mole_up), 32'd0);
        chk("coinc_miss", 32'(miss_count), 32'd1);
        chk("coinc_time", 32'(time_left), 32'd23);
        @(negedge clk);
        hit_btn = '0;

        // 5. Play out the clock; every fresh mole must differ from the last one
        for (int i = 0; i < 22; i++) begin
            prev_up = mole_up;
            next_tick();
            if (prev_up == '0 && mole_up != '0) begin
                chk("run_onehot", 32'($countones(mole_up)), 32'd1);
                chk("run_norepeat", 32'(mole_up != last_mask), 32'd1);
                last_mask = mole_up;
            end
        end
        chk("pre_end_active", 32'(game_active), 32'd1);
        chk("pre_end_time", 32'(time_left), 32'd1);
        next_tick();
        chk("over_flag", 32'(game_over), 32'd1);
        chk("over_active", 32'(game_active), 32'd0);
        chk("over_mole_up", 32'(mole_up), 32'd0);
        chk("over_flash", 32'(hit_flash), 32'd0);
        chk("over_time", 32'(time_left), 32'd0);
        chk("over_score", 32'(score), 32'd2);
        chk("sat_score", 32'(sat_score), 32'd3);
        chk("sat_miss", 32'(sat_miss), 32'd0);
        chk("sat_over", 32'(sat_over), 32'd1);
        next_tick();
        chk("over_time_hold", 32'(time_left), 32'd0);
        chk("over_hold", 32'(game_over), 32'd1);

        // Restart clears the score
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        chk("restart_active", 32'(game_active), 32'd1);
        chk("restart_over", 32'(game_over), 32'd0);
        chk("restart_score", 32'(score), 32'd0);
        chk("restart_miss", 32'(miss_count), 32'd0);
        chk("restart_time", 32'(time_left), 32'd40);
        chk("restart_sat_score", 32'(sat_score), 32'd0);
        @(negedge clk);
        start = 1'b0;

        // 6. Reset mid-UP clears outputs without waiting for a clock
        next_tick();
        next_tick();
        chk("up4_onehot", 32'($countones(mole_up)), 32'd1);
        chk("up4_norepeat", 32'(mole_up != last_mask), 32'd1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("arst_mole_up", 32'(mole_up), 32'd0);
        chk("arst_active", 32'(game_active), 32'd0);
        chk("arst_time", 32'(time_left), 32'd0);
        chk("arst_score", 32'(score), 32'd0);
        chk("arst_miss", 32'(miss_count), 32'd0);
        chk("arst_flash", 32'(hit_flash), 32'd0);
        chk("arst_over", 32'(game_over), 32'd0);
        chk("arst_sat_mole", 32'(sat_mole_up), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
